// File: rtl/ipv4_cksum_ctrl_pkg.sv
// Shared types and constants for the IPv4 checksum sequencer.
// Bus widths, error codes and FSM state encodings.
package ipv4_cksum_ctrl_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;

  localparam logic [3:0] IHL_MIN = 4'd5;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_IHL     = 2'd1,
    ERR_ALIGN   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_START   = 3'd3,
    S_ACK     = 3'd4,
    S_WAIT    = 3'd5,
    S_DONE    = 3'd6,
    S_SPARE   = 3'd7
  } state_e;

endpackage

// File: rtl/ipv4_cksum_ctrl.sv
// Sequencer: fetches the IHL byte, programs the checksum engine,
// then waits for completion under a shared ACK+WAIT cycle budget.
module ipv4_cksum_ctrl
  import ipv4_cksum_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 256,
  parameter int CKSUM_FIELD_OFF = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic [ADDR_BUS-1:0] hdr_addr_i,
  output logic                done_o,
  output logic [1:0]          err_o,
  output logic                sram_ce_o,
  output logic                sram_we_o,
  output logic [ADDR_BUS-1:0] sram_addr_o,
  output logic [3:0]          sram_sel_o,
  input  logic [DATA_BUS-1:0] sram_data_i,
  output logic                sram_mux_o,
  output logic                cksum_start_o,
  output logic [ADDR_BUS-1:0] cksum_field_start_o,
  output logic [DATA_BUS-1:0] cksum_field_len_o,
  output logic [ADDR_BUS-1:0] cksum_dst_start_o,
  input  logic                cksum_ready_i
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;

  state_e              state_q, state_d;
  err_e                err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_BUS-1:0] addr_q, addr_d;
  logic                ce_q, ce_d;
  logic [ADDR_BUS-1:0] saddr_q, saddr_d;
  logic                start_q, start_d;
  logic                mux_q, mux_d;
  logic [ADDR_BUS-1:0] fs_q, fs_d;
  logic [DATA_BUS-1:0] len_q, len_d;
  logic [ADDR_BUS-1:0] dst_q, dst_d;
  logic [3:0]          ihl;
  logic                tmo;
  logic                unused_data;

  // Only the IHL nibble of either big-endian half is consumed.
  assign unused_data = ^{sram_data_i[31:28],
                         sram_data_i[23:12],
                         sram_data_i[7:0]};

  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ce_d    = FALSE;
    saddr_d = saddr_q;
    start_d = start_q;
    mux_d   = mux_q;
    fs_d    = fs_q;
    len_d   = len_q;
    dst_d   = dst_q;
    ihl     = addr_q[1] ? sram_data_i[11:8]
                        : sram_data_i[27:24];
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          addr_d = hdr_addr_i;
          if (hdr_addr_i[0]) begin
            err_d   = ERR_ALIGN;
            state_d = S_DONE;
          end else begin
            ce_d    = TRUE;
            saddr_d = hdr_addr_i;
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (ihl < IHL_MIN) begin
          err_d   = ERR_IHL;
          state_d = S_DONE;
        end else begin
          fs_d    = addr_q;
          len_d   = DATA_BUS'({ihl, 2'b00});
          dst_d   = addr_q + ADDR_BUS'(CKSUM_FIELD_OFF);
          state_d = S_START;
        end
      end
      S_START: begin
        start_d = TRUE;
        mux_d   = TRUE;
        cnt_d   = '0;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!cksum_ready_i) begin
          state_d = S_WAIT;
        end else if (tmo) begin
          start_d = FALSE;
          mux_d   = FALSE;
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end
        if (!tmo) cnt_d = cnt_q + CW'(1);
      end
      S_WAIT: begin
        // Completion outranks a budget expiring on the same cycle.
        if (cksum_ready_i) begin
          start_d = FALSE;
          mux_d   = FALSE;
          err_d   = ERR_OK;
          state_d = S_DONE;
        end else if (tmo) begin
          start_d = FALSE;
          mux_d   = FALSE;
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (!req_i) begin
          err_d   = ERR_OK;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      err_q   <= ERR_OK;
      cnt_q   <= '0;
      addr_q  <= '0;
      ce_q    <= FALSE;
      saddr_q <= '0;
      start_q <= FALSE;
      mux_q   <= FALSE;
      fs_q    <= '0;
      len_q   <= ZERO_WORD;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ce_q    <= ce_d;
      saddr_q <= saddr_d;
      start_q <= start_d;
      mux_q   <= mux_d;
      fs_q    <= fs_d;
      len_q   <= len_d;
      dst_q   <= dst_d;
    end
  end

  assign done_o              = (state_q == S_DONE);
  assign err_o               = err_q;
  assign sram_ce_o           = ce_q;
  assign sram_we_o           = FALSE;
  assign sram_addr_o         = saddr_q;
  assign sram_sel_o          = 4'b0000;
  assign sram_mux_o          = mux_q;
  assign cksum_start_o       = start_q;
  assign cksum_field_start_o = fs_q;
  assign cksum_field_len_o   = len_q;
  assign cksum_dst_start_o   = dst_q;

endmodule
